// File: rtl/dual_issue_queue.sv
// Fetch-to-decode instruction buffer: circular queue, up to two pushes and two
// issues per cycle, with the second issue slot screened for structural/data hazards.
module dual_issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk1,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid0,
  input  logic                     in_valid1,
  input  logic [31:0]              in_instr0,
  input  logic [31:0]              in_instr1,
  input  logic [31:0]              in_pc0,
  output logic                     in_ready,
  input  logic                     stall,
  output logic                     out_valid0,
  output logic                     out_valid1,
  output logic [31:0]              out_instr0,
  output logic [31:0]              out_instr1,
  output logic [31:0]              out_pc0,
  output logic [31:0]              out_pc1,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic       is_ctrl;
    logic       is_mem;
    logic       dest_v;
    logic [4:0] dest;
    logic       s1_v;
    logic [4:0] s1;
    logic       s2_v;
    logic [4:0] s2;
  } dec_t;

  // Unlisted opcodes (including 010xxx other than LW/SW) fall through as NOP.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '0;
    case (ins[31:29])
      3'b000: begin
        d.dest_v = 1'b1; d.dest = ins[15:11];
        d.s1_v   = 1'b1; d.s1   = ins[25:21];
        d.s2_v   = 1'b1; d.s2   = ins[20:16];
      end
      3'b001: begin
        d.dest_v = 1'b1; d.dest = ins[20:16];
        d.s1_v   = 1'b1; d.s1   = ins[25:21];
      end
      3'b010: begin
        if (ins[28:26] == 3'b000) begin
          d.is_mem = 1'b1;
          d.dest_v = 1'b1; d.dest = ins[20:16];
          d.s1_v   = 1'b1; d.s1   = ins[25:21];
        end else if (ins[28:26] == 3'b001) begin
          d.is_mem = 1'b1;
          d.s1_v   = 1'b1; d.s1   = ins[25:21];
          d.s2_v   = 1'b1; d.s2   = ins[20:16];
        end else begin
          d = '0;
        end
      end
      3'b011, 3'b100: d.is_ctrl = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr1_s, wr_ptr1_s;
  logic [1:0]    push_n_s, pop_n_s;
  dec_t          dec0_s, dec1_s;
  logic          pair_ok_s;

  assign rd_ptr1_s  = rd_ptr_q + AW'(1);
  assign wr_ptr1_s  = wr_ptr_q + AW'(1);
  assign out_instr0 = instr_q[rd_ptr_q];
  assign out_pc0    = pc_q[rd_ptr_q];
  assign out_instr1 = instr_q[rd_ptr1_s];
  assign out_pc1    = pc_q[rd_ptr1_s];
  assign count      = count_q;
  assign in_ready   = (CW'(DEPTH) - count_q) >= CW'(2);
  assign out_valid0 = count_q != CW'(0);
  assign out_valid1 = (count_q >= CW'(2)) && pair_ok_s;

  // Pairing rules for the second slot; R0 is compared like any other register.
  always_comb begin
    dec0_s    = decode(out_instr0);
    dec1_s    = decode(out_instr1);
    pair_ok_s = 1'b1;
    if (dec0_s.is_ctrl || dec1_s.is_ctrl) begin
      pair_ok_s = 1'b0;
    end else if (dec0_s.is_mem && dec1_s.is_mem) begin
      pair_ok_s = 1'b0;
    end else if (dec0_s.dest_v &&
                 ((dec1_s.s1_v && dec1_s.s1 == dec0_s.dest) ||
                  (dec1_s.s2_v && dec1_s.s2 == dec0_s.dest) ||
                  (dec1_s.dest_v && dec1_s.dest == dec0_s.dest))) begin
      pair_ok_s = 1'b0;
    end else begin
      pair_ok_s = 1'b1;
    end
  end

  // Push/pop amounts and next-state pointers and occupancy.
  always_comb begin
    push_n_s = 2'd0;
    if (in_valid0 && in_ready) begin
      push_n_s = in_valid1 ? 2'd2 : 2'd1;
    end else begin
      push_n_s = 2'd0;
    end
    if (stall) begin
      pop_n_s = 2'd0;
    end else begin
      pop_n_s = {1'b0, out_valid0} + {1'b0, out_valid1};
    end
    rd_ptr_d = rd_ptr_q + AW'(pop_n_s);
    wr_ptr_d = wr_ptr_q + AW'(push_n_s);
    count_d  = count_q + CW'(push_n_s) - CW'(pop_n_s);
  end

  // Pointer and occupancy registers; reset and flush both empty the queue.
  always_ff @(posedge clk1) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; the second word of a pair wraps naturally via the pointer width.
  always_ff @(posedge clk1) begin
    if (!reset && !flush && push_n_s != 2'd0) begin
      instr_q[wr_ptr_q] <= in_instr0;
      pc_q[wr_ptr_q]    <= in_pc0;
      if (push_n_s == 2'd2) begin
        instr_q[wr_ptr1_s] <= in_instr1;
        pc_q[wr_ptr1_s]    <= in_pc0 + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed plus random stimulus against a queue-based reference model of the
// dual-issue instruction buffer.
module tb_dual_issue_queue;
  localparam int DEPTH = 8;

  logic        clk1 = 1'b0;
  logic        reset, flush, in_valid0, in_valid1, stall;
  logic [31:0] in_instr0, in_instr1, in_pc0;
  logic        in_ready, out_valid0, out_valid1;
  logic [31:0] out_instr0, out_instr1, out_pc0, out_pc1;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;
  ent_t mq[$];

  dual_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk1(clk1), .reset(reset), .flush(flush),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .in_pc0(in_pc0),
    .in_ready(in_ready), .stall(stall),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_instr0(out_instr0), .out_instr1(out_instr1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .count(count)
  );

  always #5 clk1 = ~clk1;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_CTRL = 4, K_NONE = 5;

  function automatic int kind(input logic [31:0] w);
    int op;
    op = int'(w[31:26]);
    if (op < 8) return K_R;
    if (op < 16) return K_I;
    if (op == 16) return K_LW;
    if (op == 17) return K_SW;
    if (op >= 24 && op < 40) return K_CTRL;
    return K_NONE;
  endfunction

  function automatic int dst(input logic [31:0] w);
    int k;
    k = kind(w);
    if (k == K_R) return int'(w[15:11]);
    if (k == K_I || k == K_LW) return int'(w[20:16]);
    return -1;
  endfunction

  function automatic bit reads(input logic [31:0] w, input int r);
    int k;
    int a;
    int b;
    k = kind(w);
    a = int'(w[25:21]);
    b = int'(w[20:16]);
    if (r < 0) return 1'b0;
    if (k == K_R || k == K_SW) return (r == a) || (r == b);
    if (k == K_I || k == K_LW) return r == a;
    return 1'b0;
  endfunction

  function automatic bit pair_ok(input logic [31:0] a, input logic [31:0] b);
    bit mem_a;
    bit mem_b;
    mem_a = kind(a) == K_LW || kind(a) == K_SW;
    mem_b = kind(b) == K_LW || kind(b) == K_SW;
    if (kind(a) == K_CTRL || kind(b) == K_CTRL) return 1'b0;
    if (mem_a && mem_b) return 1'b0;
    if (reads(b, dst(a))) return 1'b0;
    if (dst(a) >= 0 && dst(a) == dst(b)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int issue_n();
    if (mq.size() == 0) return 0;
    if (mq.size() >= 2 && pair_ok(mq[0].ins, mq[1].ins)) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] rtype(input int op, input int rs1, input int rs2, input int rd);
    return {op[5:0], rs1[4:0], rs2[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs1, input int rt, input int imm);
    return {op[5:0], rs1[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = issue_n();
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'((DEPTH - mq.size()) >= 2));
    chk("out_valid0", 32'(out_valid0), 32'(n >= 1));
    chk("out_valid1", 32'(out_valid1), 32'(n == 2));
    if (n >= 1) begin
      chk("out_instr0", out_instr0, mq[0].ins);
      chk("out_pc0", out_pc0, mq[0].pc);
    end
    if (n == 2) begin
      chk("out_instr1", out_instr1, mq[1].ins);
      chk("out_pc1", out_pc1, mq[1].pc);
    end
  endtask

  task automatic step(input bit rst, input bit fl, input bit v0, input bit v1, input bit st,
                      input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
    int  n;
    bit  room;
    reset = rst; flush = fl; in_valid0 = v0; in_valid1 = v1; stall = st;
    in_instr0 = i0; in_instr1 = i1; in_pc0 = pc;
    check_all();
    n    = st ? 0 : issue_n();
    room = (DEPTH - mq.size()) >= 2;
    @(posedge clk1);
    if (rst || fl) begin
      mq.delete();
    end else begin
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (v0 && room) begin
        mq.push_back('{ins: i0, pc: pc});
        if (v1) mq.push_back('{ins: i1, pc: pc + 32'd1});
      end
    end
    #1;
  endtask

  task automatic push2(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc, input bit st);
    step(0, 0, 1, 1, st, a, b, pc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rnd_instr();
    int ops[9];
    ops = '{0, 2, 8, 13, 16, 17, 24, 32, 63};
    return {6'(ops[$urandom_range(0, 8)]), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom_range(0, 2047))};
  endfunction

  initial begin
    logic [31:0] nop;
    nop = 32'hFC00_0000;
    reset = 1'b1; flush = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; stall = 1'b0;
    in_instr0 = '0; in_instr1 = '0; in_pc0 = '0;
    @(posedge clk1); @(posedge clk1); #1;
    mq.delete();
    idle(2);

    push2(rtype(0, 10, 1, 20), rtype(2, 3, 2, 21), 32'd0, 0);
    chk("plan_dual_pc1", out_pc1, 32'd1);
    idle(2);
    push2(itype(8, 5, 28, 7), rtype(0, 28, 1, 22), 32'd10, 0);
    idle(3);
    push2(itype(8, 5, 28, 7), itype(13, 2, 28, 12), 32'd20, 0);
    idle(3);
    push2(itype(16, 1, 2, 0), itype(16, 3, 4, 8), 32'd30, 0);
    idle(3);
    push2(itype(24, 1, 2, 4), rtype(0, 5, 6, 7), 32'd40, 0);
    idle(3);
    push2(nop, nop, 32'd50, 0);
    idle(2);

    // Fill under stall, overflow attempt, then drain with pointer wrap.
    step(0, 1, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    push2(nop, rtype(0, 1, 2, 3), 32'd100, 1);
    push2(rtype(0, 4, 5, 6), itype(8, 7, 8, 1), 32'd102, 1);
    push2(nop, nop, 32'd104, 1);
    step(0, 0, 1, 0, 1, itype(16, 9, 10, 0), 32'd0, 32'd106);
    chk("plan_full_ready", 32'(in_ready), 32'd0);
    push2(nop, nop, 32'd200, 1);
    push2(itype(17, 1, 2, 0), itype(16, 3, 4, 0), 32'd110, 0);
    push2(nop, nop, 32'd112, 0);
    push2(rtype(0, 1, 1, 1), rtype(0, 1, 1, 1), 32'd114, 0);
    idle(6);

    push2(nop, nop, 32'd300, 1);
    push2(nop, nop, 32'd302, 1);
    step(0, 0, 1, 0, 1, nop, nop, 32'd304);
    step(0, 1, 1, 1, 0, nop, nop, 32'd305);
    chk("plan_flush_count", 32'(count), 32'd0);
    push2(nop, rtype(0, 1, 2, 3), 32'd400, 1);
    step(1, 0, 1, 1, 0, nop, nop, 32'd402);
    chk("plan_reset_valid0", 32'(out_valid0), 32'd0);

    for (int i = 0; i < 500; i++) begin
      step(0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, rnd_instr(), rnd_instr(), $urandom());
    end
    idle(6);
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
